// File: rtl/vmmul_result_wb.sv
// Purpose : buffers the VMMUL result stream in a FIFO and drains it to the data-memory write port.
// Latency : a word pushed into an empty FIFO at edge N raises mem_req from edge N+1; 1 word/cycle sustained.
// Backpressure: none upstream (words arriving when full are dropped, overflow sticks); downstream req/gnt.
// Optional : RESULT_WB_ALIGN_CHECK_EN rejects non-word-aligned addresses and reports them on align_err.
module vmmul_result_wb #(
    parameter int DEPTH      = 16,
    parameter int TILE_WORDS = 16,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_data,
    input  logic [AW-1:0]          in_addr,
    input  logic                   flush,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_gnt,
    output logic                   wb_done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef RESULT_WB_ALIGN_CHECK_EN
    ,
    output logic                   align_err
`endif
);

    localparam int PW = $clog2(DEPTH) + 1;       // pointer width, MSB separates full from empty
    localparam int IW = PW - 1;                  // storage index width
    localparam int CW = $clog2(TILE_WORDS + 1);  // tile counter width

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_ptr_inc;
    logic [PW-1:0] level;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          full;
    logic          pop;
    logic          push;
    logic          word_ok;

    // Occupancy is a pure function of the pointer registers.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == PW'(DEPTH));

    // The head leaves the FIFO only when memory grants it; flush overrides the grant.
    assign pop   = (state_q == ISSUE) && mem_gnt && !flush;

`ifdef RESULT_WB_ALIGN_CHECK_EN
    logic aerr_q, aerr_d;
    assign word_ok   = (in_addr[1:0] == 2'b00);
    assign align_err = aerr_q;
`else
    assign word_ok   = 1'b1;
`endif

    // A slot freed by this cycle's grant may be refilled on the same edge.
    assign push = in_valid && word_ok && (!full || pop) && !flush;

    // Payload storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q[IW-1:0]] <= in_addr;
            data_mem[wr_ptr_q[IW-1:0]] <= in_data;
        end
    end

    // Next-state: pointers, request FSM, tile counter and sticky flags; flush wins over everything.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_ptr_inc = rd_ptr_q + PW'(1);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (in_valid && word_ok && full && !pop) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (level != '0) begin
                    state_d = ISSUE;
                    addr_d  = addr_mem[rd_ptr_q[IW-1:0]];
                    wdata_d = data_mem[rd_ptr_q[IW-1:0]];
                end
            end
            ISSUE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_inc;
                    if (cnt_q == CW'(TILE_WORDS - 1)) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // Keep issuing back-to-back: next stored word, else the word arriving now.
                    if (level > PW'(1)) begin
                        addr_d  = addr_mem[rd_ptr_inc[IW-1:0]];
                        wdata_d = data_mem[rd_ptr_inc[IW-1:0]];
                    end else if (push) begin
                        addr_d  = in_addr;
                        wdata_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
            addr_d   = '0;
            wdata_d  = '0;
        end
    end

    // State registers; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef RESULT_WB_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by flush or reset.
    always_comb begin
        aerr_d = aerr_q;
        if (in_valid && !word_ok) begin
            aerr_d = 1'b1;
        end
        if (flush) begin
            aerr_d = 1'b0;
        end
    end

    // Misalignment flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aerr_q <= 1'b0;
        end else begin
            aerr_q <= aerr_d;
        end
    end
`endif

    assign mem_req    = (state_q == ISSUE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign wb_done    = done_q;
    assign overflow   = ovf_q;
    assign fifo_level = level;

endmodule

// File: tb/tb_vmmul_result_wb.sv
// Bench for vmmul_result_wb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations, then random traffic.
module tb_vmmul_result_wb;

    localparam int DEPTH = 16;
    localparam int TILE  = 16;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [AW-1:0] in_addr  = '0;
    logic          flush    = 1'b0;
    logic          mem_gnt  = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          wb_done;
    logic          overflow;
    logic [4:0]    fifo_level;
`ifdef RESULT_WB_ALIGN_CHECK_EN
    logic          align_err;
`endif

    vmmul_result_wb #(.DEPTH(DEPTH), .TILE_WORDS(TILE), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .wb_done    (wb_done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
`ifdef RESULT_WB_ALIGN_CHECK_EN
        ,
        .align_err  (align_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The FIFO is a queue of {addr,data}; q[0] is the word being offered to memory.
    logic [63:0] q[$];
    bit          m_req;
    int          m_cnt;
    bit          m_done;
    bit          m_ovf;
    bit          m_aerr;
    bit          mp;
    int          msz;
    bit          mok;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_req = 0; m_cnt = 0; m_done = 0; m_ovf = 0; m_aerr = 0;
        end else if (flush) begin
            q.delete();
            m_req = 0; m_cnt = 0; m_done = 0; m_ovf = 0; m_aerr = 0;
        end else begin
            mp     = m_req && mem_gnt;
            msz    = q.size();
            m_done = 0;
            mok    = 1;
`ifdef RESULT_WB_ALIGN_CHECK_EN
            mok = (in_addr[1:0] == 2'b00);
            if (in_valid && !mok) m_aerr = 1;
`endif
            if (mp) begin
                void'(q.pop_front());
                m_cnt++;
                if (m_cnt == TILE) begin
                    m_cnt  = 0;
                    m_done = 1;
                end
            end
            if (in_valid && mok) begin
                if (msz < DEPTH || mp) q.push_back({in_addr, in_data});
                else m_ovf = 1;
            end
            if (mp) m_req = (q.size() > 0);
            else if (!m_req) m_req = (msz > 0);
        end
    end

    // ---------------- compare process + write log ----------------
    logic [63:0] wlog[$];
    int          ndone = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("mem_req", mem_req, m_req);
            if (m_req && q.size() > 0) begin
                check("mem_addr", mem_addr, q[0][63:32]);
                check("mem_wdata", mem_wdata, q[0][31:0]);
            end
            check("wb_done", wb_done, m_done);
            check("overflow", overflow, m_ovf);
            check("fifo_level", fifo_level, q.size());
`ifdef RESULT_WB_ALIGN_CHECK_EN
            check("align_err", align_err, m_aerr);
`endif
            if (mem_req && mem_gnt && !flush) wlog.push_back({mem_addr, mem_wdata});
            if (wb_done) ndone++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick();
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic idle_in();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    int  base;
    int  dbase;
    bit  reached;

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", mem_req, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", wb_done, 0);
        check("rst_addr", mem_addr, 0);
        rst = 1'b0;

        // ---- 1: 16 back-to-back pushes with grant tied high ----
        mem_gnt = 1'b1;
        base  = wlog.size();
        dbase = ndone;
        for (int i = 0; i < 16; i++) begin
            push_word(32'h1000 + 4 * i, 130 + 10 * i);
            if (i == 1) begin
                @(negedge clk);
                check("t1_req_at_push", mem_req, 0);
            end
            if (i == 2) begin
                @(negedge clk);
                check("t1_req_at_push_plus1", mem_req, 1);
            end
        end
        idle_in();
        repeat (20) tick();
        check("t1_writes", wlog.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < wlog.size())
                check("t1_order", wlog[base + i], {32'h1000 + 32'(4 * i), 32'(130 + 10 * i)});
        end
        check("t1_done", ndone - dbase, 1);
        check("t1_ovf", overflow, 0);

        // ---- 2: request held while grant withheld ----
        mem_gnt = 1'b0;
        base = wlog.size();
        push_word(32'h2000, 32'hDEAD);
        idle_in();
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t2_req_held", mem_req, 1);
            check("t2_addr_held", mem_addr, 32'h2000);
            check("t2_data_held", mem_wdata, 32'hDEAD);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        @(negedge clk);
        check("t2_granted", wlog.size() - base, 1);
        if (wlog.size() > base) check("t2_word", wlog[base], 64'h0000_2000_0000_DEAD);
        check("t2_req_drop", mem_req, 0);

        // ---- 3: 17 pushes into a stalled FIFO ----
        do_flush();
        base  = wlog.size();
        dbase = ndone;
        for (int i = 0; i < 17; i++) push_word(32'h3000 + 4 * i, 1000 + i);
        idle_in();
        @(negedge clk);
        check("t3_level_full", fifo_level, 16);
        check("t3_ovf", overflow, 1);
        mem_gnt = 1'b1;
        repeat (25) tick();
        mem_gnt = 1'b0;
        check("t3_writes", wlog.size() - base, 16);
        check("t3_done", ndone - dbase, 1);
        if (wlog.size() >= base + 16) check("t3_last", wlog[base + 15], {32'h303C, 32'd1015});

        // ---- 4: full FIFO with simultaneous push and grant ----
        do_flush();
        for (int i = 0; i < 16; i++) push_word(32'h4000 + 4 * i, 2000 + i);
        idle_in();
        tick();
        check("t4_pre_level", fifo_level, 16);
        in_valid = 1'b1;
        in_addr  = 32'h4040;
        in_data  = 32'd2016;
        mem_gnt  = 1'b1;
        tick();
        in_valid = 1'b0;
        mem_gnt  = 1'b0;
        @(negedge clk);
        check("t4_level", fifo_level, 16);
        check("t4_ovf", overflow, 0);
        mem_gnt = 1'b1;
        repeat (22) tick();
        mem_gnt = 1'b0;

        // ---- 5: asynchronous reset mid-drain ----
        do_flush();
        mem_gnt = 1'b1;
        base    = wlog.size();
        reached = 0;
        for (int i = 0; i < 16; i++) begin
            push_word(32'h5000 + 4 * i, 3000 + i);
            if (wlog.size() - base >= 5) begin
                reached = 1;
                break;
            end
        end
        check("t5_reached_5", reached, 1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_req", mem_req, 0);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_addr", mem_addr, 0);
        check("t5_rst_data", mem_wdata, 0);
        check("t5_rst_done", wb_done, 0);
        check("t5_rst_ovf", overflow, 0);
        repeat (2) tick();
        rst   = 1'b0;
        base  = wlog.size();
        dbase = ndone;
        for (int i = 0; i < 16; i++) push_word(32'h6000 + 4 * i, 4000 + i);
        idle_in();
        repeat (20) tick();
        check("t5_writes", wlog.size() - base, 16);
        check("t5_done", ndone - dbase, 1);
        mem_gnt = 1'b0;

`ifdef RESULT_WB_ALIGN_CHECK_EN
        // ---- 6: misaligned address rejected ----
        do_flush();
        mem_gnt = 1'b1;
        base = wlog.size();
        push_word(32'h1002, 32'h77);
        idle_in();
        repeat (5) tick();
        @(negedge clk);
        check("t6_align_err", align_err, 1);
        check("t6_no_write", wlog.size() - base, 0);
        check("t6_level", fifo_level, 0);
        do_flush();
        @(negedge clk);
        check("t6_align_clr", align_err, 0);
        check("t6_level_flush", fifo_level, 0);
        mem_gnt = 1'b0;
`endif

        // ---- random traffic, model-checked every cycle ----
        do_flush();
        for (int i = 0; i < 600; i++) begin
            tick();
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = $urandom();
            in_addr  = $urandom();
            if ($urandom_range(0, 7) != 0) in_addr[1:0] = 2'b00;
            if (i < 300) mem_gnt = ($urandom_range(0, 3) == 0);
            else         mem_gnt = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 59) == 0);
        end
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        mem_gnt  = 1'b1;
        repeat (25) tick();
        check("final_drained", fifo_level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
